adc_angle_sequencer: RTL and testbench
======================================

// Module: adc_angle_sequencer
// PURPOSE
//  Front-end stage ahead of the angle registers: drives an ADC0808-style 8-bit converter,
//  alternates channel 0 (X tilt) and channel 1 (Y tilt), and captures each result.
//  Outputs x_angle/y_angle feed the LED bar, LCD controller and servo PWM stages.
//  Conversions are paced by a refresh tick; a timeout guards a dead converter.
// PARAMETERS
//  CLK_DIV     25    clk cycles per adc_clk half-period (adc_clk = clk / (2*CLK_DIV))
//  SETTLE      4     clk cycles the ALE and OE strobes are held high
//  EOC_TIMEOUT 8191  max clk cycles spent in each EOC wait state before abort
//  AVG_SHIFT   2     filter depth 2^AVG_SHIFT (used only with ANGLE_AVG_EN)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  enable       in   1  one-cycle refresh tick; starts one X+Y conversion pair
//  adc_data     in   8  converter parallel output, valid while adc_oe=1
//  adc_eoc      in   1  converter end-of-conversion (low = busy)
//  adc_clk      out  1  free-running converter clock
//  adc_addr     out  1  channel select: 0 = X, 1 = Y
//  adc_ale      out  1  address latch enable strobe
//  adc_start    out  1  conversion start pulse
//  adc_oe       out  1  converter output enable
//  x_angle      out  8  latest X result
//  y_angle      out  8  latest Y result
//  angle_valid  out  1  one-cycle pulse after the Y result of a pair is written
//  timeout_err  out  1  sticky; set on any EOC timeout, cleared only by rst
// BEHAVIOUR
//  Reset (sync, next clk edge, also mid-conversion): all outputs 0, FSM=IDLE, counters 0.
//  adc_clk: toggles every CLK_DIV clk cycles from reset; independent of the FSM.
//  FSM: IDLE -> ADDR -> START -> WAIT_LO -> WAIT_HI -> READ -> NEXT.
//   IDLE:    adc_addr=0; on enable=1 -> ADDR. enable outside IDLE is ignored (no queue).
//   ADDR:    adc_ale=1 for SETTLE cycles, address stable 1 cycle before and after.
//   START:   adc_start=1 for 2*CLK_DIV cycles (one full adc_clk period).
//   WAIT_LO: wait adc_eoc=0; WAIT_HI: wait adc_eoc=1. Timeout counter restarts on entry.
//   READ:    adc_oe=1 for SETTLE cycles; adc_data sampled on the last OE cycle.
//   NEXT:    write sample to x_angle (addr=0) or y_angle (addr=1), 1 cycle later.
//            addr=0 -> addr<=1, ADDR; addr=1 -> angle_valid=1, addr<=0, IDLE.
//  Timeout: counter reaches EOC_TIMEOUT in WAIT_LO/WAIT_HI -> timeout_err<=1, that
//   channel's angle left unchanged, proceed to NEXT without writing (valid still pulses on Y).
//  Latency: enable to angle_valid = 2*(SETTLE+2*CLK_DIV+SETTLE+3) + EOC wait times.
//  enable and a timeout on the same edge: timeout wins; enable dropped.
//  Strobes adc_ale/adc_start/adc_oe are registered, glitch-free, never overlap.
// CONFIGURATION
//  ANGLE_AVG_EN defined: per-channel accumulator acc (8+AVG_SHIFT bits);
//   first valid sample after reset seeds acc = sample<<AVG_SHIFT;
//   then acc <= acc - (acc>>AVG_SHIFT) + sample; angle = acc>>AVG_SHIFT (truncate).
//   Timeout samples do not touch acc.
//  ANGLE_AVG_EN undefined: angle = raw sample; no accumulators synthesized.
// TESTING
//  T1 reset: hold rst 3 cycles mid-READ -> all outputs 0 next edge, FSM IDLE.
//  T2 pair: enable pulse, ADC model returns X=0x40, Y=0xC0 -> x_angle=0x40,
//     y_angle=0xC0, one angle_valid pulse, ALE/START/OE order and widths checked.
//  T3 timeout: hold adc_eoc=1 forever on X -> after EOC_TIMEOUT cycles timeout_err=1,
//     x_angle unchanged, Y still converted, angle_valid pulses; err sticky until rst.
//  T4 busy enable: extra enable pulses during conversion -> exactly one pair per
//     IDLE-accepted enable; no extra ALE.
//  T5 ANGLE_AVG_EN, AVG_SHIFT=2: X samples 0x80,0x00,0x00 -> x_angle 0x80,0x60,0x48.
//  T6 no ANGLE_AVG_EN: same stimulus -> x_angle 0x80,0x00,0x00.

Source files
------------

// File: rtl/adc_angle_sequencer.sv
// ADC0808-style front end: alternates X (ch0) and Y (ch1) conversions per refresh tick.
// Optional smoothing filter enabled by defining ANGLE_AVG_EN.
module adc_angle_sequencer #(
    parameter int CLK_DIV     = 25,
    parameter int SETTLE      = 4,
    parameter int EOC_TIMEOUT = 8191,
    parameter int AVG_SHIFT   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [7:0] i_adc_data,
    input  logic       i_adc_eoc,
    output logic       o_adc_clk,
    output logic       o_adc_addr,
    output logic       o_adc_ale,
    output logic       o_adc_start,
    output logic       o_adc_oe,
    output logic [7:0] o_x_angle,
    output logic [7:0] o_y_angle,
    output logic       o_angle_valid,
    output logic       o_timeout_err
);
    localparam int CNT_W = $clog2(2 * CLK_DIV + SETTLE + EOC_TIMEOUT + 2);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_NEXT
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [DIV_W-1:0]   r_div;
    logic               r_adc_clk;
    logic               r_addr, w_addr_next;
    logic               r_ale, r_start, r_oe;
    logic               w_ale_next, w_start_next, w_oe_next;
    logic               r_valid, w_valid_next;
    logic               r_to_flag, w_to_flag_next;
    logic               r_err, w_timeout_set;
    logic               w_sample_load, w_write;
    logic [7:0]         r_sample, w_angle_new;
    logic [7:0]         r_x_angle, r_y_angle;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_adc_clk <= 1'b0;
        end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
            r_div     <= '0;
            r_adc_clk <= ~r_adc_clk;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 1'b1;
        w_addr_next    = r_addr;
        w_valid_next   = 1'b0;
        w_to_flag_next = r_to_flag;
        w_timeout_set  = 1'b0;
        w_sample_load  = 1'b0;
        w_write        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_addr_next = 1'b0;
                if (i_enable) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                if (r_cnt == CNT_W'(SETTLE + 1)) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
                    w_state_next = S_WAIT_LO;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT_LO, S_WAIT_HI: begin
                // WAIT_LO waits for EOC low, WAIT_HI for EOC high again
                if ((r_state == S_WAIT_LO) ? !i_adc_eoc : i_adc_eoc) begin
                    w_state_next = (r_state == S_WAIT_LO) ? S_WAIT_HI : S_READ;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
                    w_state_next   = S_NEXT;
                    w_cnt_next     = '0;
                    w_to_flag_next = 1'b1;
                    w_timeout_set  = 1'b1;
                end
            end
            S_READ: begin
                if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_state_next  = S_NEXT;
                    w_cnt_next    = '0;
                    w_sample_load = 1'b1;
                end
            end
            S_NEXT: begin
                w_write        = !r_to_flag;
                w_to_flag_next = 1'b0;
                w_cnt_next     = '0;
                if (!r_addr) begin
                    w_addr_next  = 1'b1;
                    w_state_next = S_ADDR;
                end else begin
                    w_addr_next  = 1'b0;
                    w_valid_next = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Strobes decoded from the next state so they register in step with the FSM
    assign w_ale_next   = (w_state_next == S_ADDR) && (w_cnt_next >= CNT_W'(1))
                          && (w_cnt_next <= CNT_W'(SETTLE));
    assign w_start_next = (w_state_next == S_START);
    assign w_oe_next    = (w_state_next == S_READ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= 1'b0;
            r_ale     <= 1'b0;
            r_start   <= 1'b0;
            r_oe      <= 1'b0;
            r_valid   <= 1'b0;
            r_to_flag <= 1'b0;
            r_err     <= 1'b0;
            r_sample  <= '0;
            r_x_angle <= '0;
            r_y_angle <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_addr    <= w_addr_next;
            r_ale     <= w_ale_next;
            r_start   <= w_start_next;
            r_oe      <= w_oe_next;
            r_valid   <= w_valid_next;
            r_to_flag <= w_to_flag_next;
            r_err     <= r_err | w_timeout_set;
            if (w_sample_load) r_sample <= i_adc_data;
            if (w_write && !r_addr) r_x_angle <= w_angle_new;
            if (w_write && r_addr)  r_y_angle <= w_angle_new;
        end
    end

`ifdef ANGLE_AVG_EN
    localparam int ACC_W = 8 + AVG_SHIFT;
    logic [ACC_W-1:0] r_acc_x, r_acc_y, w_acc_cur, w_acc_next;
    logic [1:0]       r_seeded;

    assign w_acc_cur   = r_addr ? r_acc_y : r_acc_x;
    assign w_acc_next  = r_seeded[r_addr]
                         ? (w_acc_cur - (w_acc_cur >> AVG_SHIFT) + ACC_W'(r_sample))
                         : (ACC_W'(r_sample) << AVG_SHIFT);
    assign w_angle_new = w_acc_next[ACC_W-1:AVG_SHIFT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_x  <= '0;
            r_acc_y  <= '0;
            r_seeded <= '0;
        end else if (w_write) begin
            r_seeded[r_addr] <= 1'b1;
            if (r_addr) r_acc_y <= w_acc_next;
            else        r_acc_x <= w_acc_next;
        end
    end
`else
    assign w_angle_new = r_sample;
`endif

    assign o_adc_clk     = r_adc_clk;
    assign o_adc_addr    = r_addr;
    assign o_adc_ale     = r_ale;
    assign o_adc_start   = r_start;
    assign o_adc_oe      = r_oe;
    assign o_x_angle     = r_x_angle;
    assign o_y_angle     = r_y_angle;
    assign o_angle_valid = r_valid;
    assign o_timeout_err = r_err;
endmodule

// File: tb/tb_adc_angle_sequencer.sv
// Scoreboard bench for adc_angle_sequencer with a behavioural ADC0808 model.
// Follows ANGLE_AVG_EN the same way as the design build.
module tb_adc_angle_sequencer;
    localparam int CLK_DIV = 25, SETTLE = 4, EOC_TIMEOUT = 8191, AVG_SHIFT = 2;

    logic clk = 0, rst = 1, enable = 0;
    logic [7:0] adc_data = 0;
    logic adc_eoc = 1;
    logic adc_clk, adc_addr, adc_ale, adc_start, adc_oe, angle_valid, timeout_err;
    logic [7:0] x_angle, y_angle;

    adc_angle_sequencer #(.CLK_DIV(CLK_DIV), .SETTLE(SETTLE), .EOC_TIMEOUT(EOC_TIMEOUT),
                          .AVG_SHIFT(AVG_SHIFT)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_adc_data(adc_data),
        .i_adc_eoc(adc_eoc), .o_adc_clk(adc_clk), .o_adc_addr(adc_addr),
        .o_adc_ale(adc_ale), .o_adc_start(adc_start), .o_adc_oe(adc_oe),
        .o_x_angle(x_angle), .o_y_angle(y_angle), .o_angle_valid(angle_valid),
        .o_timeout_err(timeout_err));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int valid_count = 0, ale_count = 0;

    typedef struct {logic [7:0] x; logic [7:0] y; logic err;} exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: angle per channel from the filtering rule, sticky error
    int acc_m [2];
    bit seeded_m [2];
    logic [7:0] x_m = 0, y_m = 0;
    logic err_m = 0;

    function automatic logic [7:0] filt(int ch, int s);
`ifdef ANGLE_AVG_EN
        int d;
        d = 2 ** AVG_SHIFT;
        if (!seeded_m[ch]) begin
            acc_m[ch] = s * d;
            seeded_m[ch] = 1;
        end else begin
            acc_m[ch] = acc_m[ch] - acc_m[ch] / d + s;
        end
        return 8'(acc_m[ch] / d);
`else
        seeded_m[ch] = 1;
        return 8'(s);
`endif
    endfunction

    // Behavioural ADC: channel latched on ALE, EOC drops after START, result on rise
    logic [7:0] adc_val [2];
    bit hang_x = 0;
    bit model_ch = 0;

    always @(negedge clk) if (adc_ale) model_ch = adc_addr;

    initial begin
        forever begin
            do @(negedge clk); while (!adc_start);
            do @(negedge clk); while (adc_start);
            if (!(hang_x && model_ch == 0)) begin
                adc_data = 8'($urandom);
                repeat ($urandom_range(0, 5)) @(negedge clk);
                adc_eoc = 0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                adc_data = adc_val[model_ch];
                adc_eoc = 1;
            end
        end
    end

    // Monitor: pop the expected pair on each angle_valid
    always @(negedge clk) begin
        if (!rst && angle_valid) begin
            valid_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got angle_valid with empty scoreboard");
            end else begin
                mon_e = sb.pop_front();
                check("x_angle", x_angle, mon_e.x);
                check("y_angle", y_angle, mon_e.y);
                check("timeout_err", timeout_err, mon_e.err);
            end
        end
    end

    // Strobe protocol checker: order, widths, exclusivity, address stability
    logic p_ale = 0, p_start = 0, p_oe = 0, p_addr = 0, exp_ch = 0;
    int w_ale = 0, w_start = 0, w_oe = 0, last_strobe = 0;
    bit overlap = 0;
    always @(negedge clk) begin
        if (rst) begin
            p_ale = 0; p_start = 0; p_oe = 0; exp_ch = 0;
            w_ale = 0; w_start = 0; w_oe = 0; last_strobe = 0; overlap = 0;
        end else begin
            if (int'(adc_ale) + int'(adc_start) + int'(adc_oe) > 1) overlap = 1;
            if (adc_ale && !p_ale) begin
                ale_count++;
                check("ale_not_after_ale", last_strobe != 1, 1);
                check("addr_setup", adc_addr, p_addr);
                check("ale_channel", adc_addr, exp_ch);
                exp_ch = !exp_ch;
            end
            if (!adc_ale && p_ale) begin
                check("ale_width", w_ale, SETTLE);
                check("addr_hold", adc_addr, p_addr);
                last_strobe = 1;
            end
            if (adc_start && !p_start) check("start_after_ale", last_strobe, 1);
            if (!adc_start && p_start) begin
                check("start_width", w_start, 2 * CLK_DIV);
                last_strobe = 2;
            end
            if (adc_oe && !p_oe) check("oe_after_start", last_strobe, 2);
            if (!adc_oe && p_oe) begin
                check("oe_width", w_oe, SETTLE);
                check("strobe_overlap", overlap, 0);
                last_strobe = 3;
            end
            w_ale   = adc_ale   ? w_ale + 1   : 0;
            w_start = adc_start ? w_start + 1 : 0;
            w_oe    = adc_oe    ? w_oe + 1    : 0;
            p_ale = adc_ale; p_start = adc_start; p_oe = adc_oe;
        end
        p_addr = adc_addr;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_x_angle"}, x_angle, 0);
        check({tag, "_y_angle"}, y_angle, 0);
        check({tag, "_valid"}, angle_valid, 0);
        check({tag, "_err"}, timeout_err, 0);
        check({tag, "_ale"}, adc_ale, 0);
        check({tag, "_start"}, adc_start, 0);
        check({tag, "_oe"}, adc_oe, 0);
        check({tag, "_addr"}, adc_addr, 0);
        check({tag, "_adc_clk"}, adc_clk, 0);
    endtask

    task automatic pulse_enable();
        @(negedge clk); enable = 1;
        @(negedge clk); enable = 0;
    endtask

    task automatic run_pair(input logic [7:0] xv, input logic [7:0] yv, input bit hang,
                            input bit poke);
        int pv, pa, n;
        pv = valid_count;
        pa = ale_count;
        adc_val[0] = xv;
        adc_val[1] = yv;
        hang_x = hang;
        if (hang) err_m = 1;
        else x_m = filt(0, xv);
        y_m = filt(1, yv);
        sb.push_back('{x_m, y_m, err_m});
        pulse_enable();
        if (poke) begin
            repeat (10) @(negedge clk);
            pulse_enable();
            repeat (60) @(negedge clk);
            pulse_enable();
        end
        if (hang) begin
            n = 0;
            while (!adc_start && n < 500) begin @(negedge clk); n++; end
            while (adc_start && n < 500) begin @(negedge clk); n++; end
            n = 0;
            while (!timeout_err && n < EOC_TIMEOUT + 100) begin @(negedge clk); n++; end
            check("timeout_delay_ok", (n >= EOC_TIMEOUT - 2) && (n <= EOC_TIMEOUT + 2), 1);
        end
        n = 0;
        while (valid_count == pv && n < 12000) begin @(negedge clk); n++; end
        check("pair_completed", valid_count - pv, 1);
        repeat (5) @(negedge clk);
        check("ale_pulses_per_pair", ale_count - pa, 2);
        check("valid_once", valid_count - pv, 1);
        hang_x = 0;
    endtask

    logic [7:0] x_seq_exp [3];

    initial begin
        int n;
        adc_val[0] = 0;
        adc_val[1] = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        run_pair(8'h40, 8'hC0, 0, 0);
        check("t2_x_const", x_angle, 8'h40);
        check("t2_y_const", y_angle, 8'hC0);

        for (int i = 0; i < 8; i++)
            run_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, (i % 3) == 0);

        run_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, 0);
        run_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1);
        check("err_sticky", timeout_err, 1);

        adc_val[0] = 8'h11;
        adc_val[1] = 8'h22;
        pulse_enable();
        n = 0;
        while (!adc_oe && n < 2000) begin @(negedge clk); n++; end
        check("reached_read", adc_oe, 1);
        rst = 1;
        @(negedge clk);
        check_all_zero("midread_reset");
        repeat (2) @(negedge clk);
        rst = 0;
        x_m = 0; y_m = 0; err_m = 0;
        seeded_m[0] = 0; seeded_m[1] = 0;
        acc_m[0] = 0; acc_m[1] = 0;

`ifdef ANGLE_AVG_EN
        x_seq_exp[0] = 8'h80; x_seq_exp[1] = 8'h60; x_seq_exp[2] = 8'h48;
`else
        x_seq_exp[0] = 8'h80; x_seq_exp[1] = 8'h00; x_seq_exp[2] = 8'h00;
`endif
        run_pair(8'h80, 8'($urandom_range(0, 255)), 0, 0);
        check("seq_x0", x_angle, x_seq_exp[0]);
        run_pair(8'h00, 8'($urandom_range(0, 255)), 0, 0);
        check("seq_x1", x_angle, x_seq_exp[1]);
        run_pair(8'h00, 8'($urandom_range(0, 255)), 0, 0);
        check("seq_x2", x_angle, x_seq_exp[2]);

        check("scoreboard_drained", sb.size(), 0);
        check("err_cleared_by_reset", timeout_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
